// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state encoding and default sizing for the two-master Wishbone arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADR_WIDTH  = 32;
  localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/wb_arb_timeout.sv
// rtl/wb_arb_timeout.sv - slave no-response watchdog: counts unanswered strobe cycles, pulses at the limit
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int timeout = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic resp,
  input  logic clr,
  output logic pulse
);

  generate
    if (timeout == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, stb, resp, clr};
      assign pulse = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(timeout + 1);
      logic [CW-1:0] cnt;

      // A response arriving in the limit cycle suppresses the pulse.
      assign pulse = stb && !resp && (cnt == CW'(timeout));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (!stb || resp || clr || pulse) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone arbiter with alternating tie-break and slave timeout
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int adr_width  = DEF_ADR_WIDTH,
  parameter int timeout    = DEF_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [adr_width-1:0]    m0_adr_i,
  input  logic [data_width-1:0]   m0_dat_i,
  output logic [data_width-1:0]   m0_dat_o,
  input  logic [data_width/8-1:0] m0_sel_i,
  input  logic                    m0_we_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic [adr_width-1:0]    m1_adr_i,
  input  logic [data_width-1:0]   m1_dat_i,
  output logic [data_width-1:0]   m1_dat_o,
  input  logic [data_width/8-1:0] m1_sel_i,
  input  logic                    m1_we_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [adr_width-1:0]    s_adr_o,
  output logic [data_width-1:0]   s_dat_o,
  output logic [data_width/8-1:0] s_sel_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic [data_width-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  output logic [1:0]              gnt_o
);

  arb_state_t state, state_next;
  logic       last_m1, last_m1_next;  // 1: m1 was served last, so m0 wins a tie
  logic       g0, g1, raw_stb, to_pulse;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_next;
      last_m1 <= last_m1_next;
    end
  end

  always_comb begin
    state_next   = state;
    last_m1_next = last_m1;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last_m1 ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_next = GNT0;
        else if (m1_cyc_i)        state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_m1_next = 1'b0;
          state_next   = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_m1_next = 1'b1;
          state_next   = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign g0    = (state == GNT0);
  assign g1    = (state == GNT1);
  assign gnt_o = {g1, g0};

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    raw_stb = 1'b0;
    if (g0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      raw_stb = m0_stb_i;
    end else if (g1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      raw_stb = m1_stb_i;
    end
  end

  wb_arb_timeout #(.timeout(timeout)) u_timeout (
    .clk   (clk_i),
    .rst_n (rst_i),
    .stb   (raw_stb),
    .resp  (s_ack_i | s_err_i),
    .clr   (state_next != state),
    .pulse (to_pulse)
  );

  assign s_stb_o  = raw_stb & ~to_pulse;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m0_err_o = g0 & (s_err_i | to_pulse);
  assign m1_err_o = g1 & (s_err_i | to_pulse);

endmodule
